// File: rtl/adxl345_pkg.sv
// Shared ADXL345 register map, reset values and responder FSM encoding.
// Used by both the SPI responder and the host-side driver.
package adxl345_pkg;

  localparam logic [5:0] AddrDevid      = 6'h00;
  localparam logic [5:0] AddrBwRate     = 6'h2C;
  localparam logic [5:0] AddrPowerCtl   = 6'h2D;
  localparam logic [5:0] AddrIntEnable  = 6'h2E;
  localparam logic [5:0] AddrDataFormat = 6'h31;
  localparam logic [5:0] AddrDataX0     = 6'h32;
  localparam logic [5:0] AddrDataX1     = 6'h33;
  localparam logic [5:0] AddrDataY0     = 6'h34;
  localparam logic [5:0] AddrDataY1     = 6'h35;
  localparam logic [5:0] AddrDataZ0     = 6'h36;
  localparam logic [5:0] AddrDataZ1     = 6'h37;
  localparam logic [5:0] AddrFifoCtl    = 6'h38;

  localparam logic [7:0] DevidValue  = 8'hE5;
  localparam logic [7:0] BwRateReset = 8'h0A;
  localparam logic [7:0] CtlReset    = 8'h00;

  typedef enum logic [1:0] {
    StIdle,
    StCommand,
    StData
  } state_e;

  function automatic logic is_writable(logic [5:0] addr);
    return (addr == AddrBwRate) || (addr == AddrPowerCtl) || (addr == AddrIntEnable) ||
           (addr == AddrDataFormat) || (addr == AddrFifoCtl);
  endfunction

endpackage

// File: rtl/adxl345_responder_if.sv
// Pin-level bundle of the responder: SPI pads, sample stream and register-write notifications.
interface adxl345_responder_if;

  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic [47:0] sample_tdata;
  logic        sample_tvalid;
  logic        sample_tready;
  logic        reg_wr_valid;
  logic [5:0]  reg_wr_addr;
  logic [7:0]  reg_wr_data;

  modport slave (
    input  sclk, cs_n, mosi, sample_tdata, sample_tvalid,
    output miso, miso_oe, sample_tready, reg_wr_valid, reg_wr_addr, reg_wr_data
  );

  modport master (
    output sclk, cs_n, mosi, sample_tdata, sample_tvalid,
    input  miso, miso_oe, sample_tready, reg_wr_valid, reg_wr_addr, reg_wr_data
  );

endinterface

// File: rtl/spi_slave_sync.sv
// Two-flop synchronizers for sclk/cs_n/mosi plus edge detection on the synchronized values.
module spi_slave_sync (
  input  logic sys_clk,
  input  logic reset,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_n_s,
  output logic cs_fall,
  output logic mosi_s
);

  // Bit order {sclk, cs_n, mosi}; idle bus is sclk high, cs_n high.
  logic [2:0] meta_q, sync_q;
  logic       sclk_prev_q, cs_prev_q;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      meta_q      <= 3'b110;
      sync_q      <= 3'b110;
      sclk_prev_q <= 1'b1;
      cs_prev_q   <= 1'b1;
    end else begin
      meta_q      <= {sclk, cs_n, mosi};
      sync_q      <= meta_q;
      sclk_prev_q <= sync_q[2];
      cs_prev_q   <= sync_q[1];
    end
  end

  assign sclk_rise = sync_q[2] & ~sclk_prev_q;
  assign sclk_fall = ~sync_q[2] & sclk_prev_q;
  assign cs_n_s    = sync_q[1];
  assign cs_fall   = ~sync_q[1] & cs_prev_q;
  assign mosi_s    = sync_q[0];

endmodule

// File: rtl/adxl345_responder.sv
// SPI mode-3 responder emulating the ADXL345 register interface, with sample data
// loaded coherently from an AXI-stream port while the bus is idle.
module adxl345_responder
  import adxl345_pkg::*;
#(
  parameter int unsigned SCLK_OVERSAMPLE = 8
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  adxl345_responder_if.slave   bus,
  output logic                 measure_mode
);

  if (SCLK_OVERSAMPLE < 6) begin : g_oversample_check
    $error("SCLK_OVERSAMPLE too small for synchronizer latency");
  end

  logic sclk_rise, sclk_fall, cs_n_s, cs_fall, mosi_s;

  spi_slave_sync u_sync (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .sclk      (bus.sclk),
    .cs_n      (bus.cs_n),
    .mosi      (bus.mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_n_s    (cs_n_s),
    .cs_fall   (cs_fall),
    .mosi_s    (mosi_s)
  );

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d, tx_q, tx_d;
  logic        rw_q, rw_d, mb_q, mb_d, done_q, done_d;
  logic [5:0]  addr_q, addr_d;
  logic        miso_q, miso_d;
  logic        tready_q, tready_d;
  logic        wr_valid_q, wr_valid_d;
  logic [5:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;

  logic [7:0]  bw_rate_q, power_ctl_q, int_enable_q, data_format_q, fifo_ctl_q;
  logic [47:0] data_q;

  logic [7:0]  rx_shift;
  logic [5:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        sample_hs;

  assign rx_shift  = {rx_q[6:0], mosi_s};
  assign sample_hs = bus.sample_tvalid && tready_q;

  // The command byte's address is read at the end of COMMAND; later reads prefetch addr+1.
  assign rd_addr = (state_q == StCommand) ? rx_shift[5:0] : addr_q + 6'd1;

  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      AddrDevid:      rd_data = DevidValue;
      AddrBwRate:     rd_data = bw_rate_q;
      AddrPowerCtl:   rd_data = power_ctl_q;
      AddrIntEnable:  rd_data = int_enable_q;
      AddrDataFormat: rd_data = data_format_q;
      AddrDataX0:     rd_data = data_q[7:0];
      AddrDataX1:     rd_data = data_q[15:8];
      AddrDataY0:     rd_data = data_q[23:16];
      AddrDataY1:     rd_data = data_q[31:24];
      AddrDataZ0:     rd_data = data_q[39:32];
      AddrDataZ1:     rd_data = data_q[47:40];
      AddrFifoCtl:    rd_data = fifo_ctl_q;
      default:        rd_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    rw_d       = rw_q;
    mb_d       = mb_q;
    done_d     = done_q;
    addr_d     = addr_q;
    miso_d     = miso_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d   = StCommand;
          bit_cnt_d = 3'd0;
          rx_d      = 8'h00;
          done_d    = 1'b0;
          miso_d    = 1'b0;
        end
      end
      StCommand: begin
        if (sclk_fall) miso_d = 1'b0;
        if (sclk_rise) begin
          rx_d      = rx_shift;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rw_d    = rx_shift[7];
            mb_d    = rx_shift[6];
            addr_d  = rx_shift[5:0];
            tx_d    = rd_data;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (sclk_fall) begin
          if (rw_q && !done_q) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end else begin
            miso_d = 1'b0;
          end
        end
        if (sclk_rise && !done_q) begin
          rx_d      = rx_shift;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (!rw_q && is_writable(addr_q)) begin
              wr_valid_d = 1'b1;
              wr_addr_d  = addr_q;
              wr_data_d  = rx_shift;
            end
            if (mb_q) begin
              addr_d = addr_q + 6'd1;
              tx_d   = rd_data;
            end else begin
              done_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Deselect wins over everything: partial bytes are dropped without a write.
    if (cs_n_s) begin
      state_d    = StIdle;
      bit_cnt_d  = 3'd0;
      miso_d     = 1'b0;
      wr_valid_d = 1'b0;
    end
  end

  // Registered one cycle behind, so a sample offered as cs_n falls is still accepted.
  assign tready_d = (state_d == StIdle) && cs_n_s;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      bit_cnt_q     <= 3'd0;
      rx_q          <= 8'h00;
      tx_q          <= 8'h00;
      rw_q          <= 1'b0;
      mb_q          <= 1'b0;
      done_q        <= 1'b0;
      addr_q        <= 6'h00;
      miso_q        <= 1'b0;
      tready_q      <= 1'b0;
      wr_valid_q    <= 1'b0;
      wr_addr_q     <= 6'h00;
      wr_data_q     <= 8'h00;
      bw_rate_q     <= BwRateReset;
      power_ctl_q   <= CtlReset;
      int_enable_q  <= CtlReset;
      data_format_q <= CtlReset;
      fifo_ctl_q    <= CtlReset;
      data_q        <= 48'h0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      rw_q       <= rw_d;
      mb_q       <= mb_d;
      done_q     <= done_d;
      addr_q     <= addr_d;
      miso_q     <= miso_d;
      tready_q   <= tready_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      if (sample_hs) data_q <= bus.sample_tdata;
      if (wr_valid_d) begin
        case (wr_addr_d)
          AddrBwRate:     bw_rate_q     <= wr_data_d;
          AddrPowerCtl:   power_ctl_q   <= wr_data_d;
          AddrIntEnable:  int_enable_q  <= wr_data_d;
          AddrDataFormat: data_format_q <= wr_data_d;
          AddrFifoCtl:    fifo_ctl_q    <= wr_data_d;
          default: ;
        endcase
      end
    end
  end

  assign bus.miso          = miso_q;
  assign bus.miso_oe       = ~cs_n_s;
  assign bus.sample_tready = tready_q;
  assign bus.reg_wr_valid  = wr_valid_q;
  assign bus.reg_wr_addr   = wr_addr_q;
  assign bus.reg_wr_data   = wr_data_q;
  assign measure_mode      = power_ctl_q[3];

endmodule

// File: tb/tb_adxl345_responder.sv
// Self-checking bench for adxl345_responder: an SPI mode-3 master against a register-map model.
module tb_adxl345_responder;

  localparam int Half = 4;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  logic measure_mode;

  adxl345_responder_if bus ();

  adxl345_responder #(.SCLK_OVERSAMPLE(8)) dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .bus          (bus),
    .measure_mode (measure_mode)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mtx [8];
  logic [7:0]  mrx [8];
  logic        oe_ok;
  logic [13:0] wr_log [$];

  // Reference model: plain register array plus the latest accepted sample.
  logic [7:0]  m_regs [64];
  logic [47:0] m_sample;

  always @(negedge sys_clk)
    if (!reset && bus.reg_wr_valid) wr_log.push_back({bus.reg_wr_addr, bus.reg_wr_data});

  function automatic logic [7:0] m_read(int a);
    int aa = a % 64;
    if (aa >= 50 && aa <= 55) return m_sample[8*(aa-50) +: 8];
    return m_regs[aa];
  endfunction

  function automatic bit m_writable(int a);
    return a == 44 || a == 45 || a == 46 || a == 49 || a == 56;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 64; k++) m_regs[k] = 8'h00;
    m_regs[0]  = 8'hE5;
    m_regs[44] = 8'h0A;
    m_sample   = 48'h0;
  endtask

  task automatic spi_open(input int nbits);
    for (int k = 0; k < 8; k++) mrx[k] = 8'h00;
    oe_ok = 1'b1;
    bus.cs_n = 1'b0;
    repeat (6) @(negedge sys_clk);
    for (int i = 0; i < nbits; i++) begin
      bus.sclk = 1'b0;
      bus.mosi = mtx[i/8][7-(i%8)];
      repeat (Half) @(negedge sys_clk);
      mrx[i/8] = {mrx[i/8][6:0], bus.miso};
      if (bus.miso_oe !== 1'b1) oe_ok = 1'b0;
      bus.sclk = 1'b1;
      repeat (Half) @(negedge sys_clk);
    end
  endtask

  task automatic spi_close();
    bus.cs_n = 1'b1;
    repeat (8) @(negedge sys_clk);
  endtask

  task automatic spi_read(input logic [5:0] addr, input logic mb, input int n);
    mtx[0] = {1'b1, mb, addr};
    for (int k = 1; k < 8; k++) mtx[k] = 8'($urandom);
    spi_open(8 * (n + 1));
    spi_close();
  endtask

  task automatic spi_write(input logic [5:0] addr, input logic [7:0] data);
    mtx[0] = {2'b00, addr};
    mtx[1] = data;
    spi_open(16);
    spi_close();
  endtask

  task automatic push_sample(input logic [47:0] d, output logic acc);
    acc = 1'b0;
    bus.sample_tdata  = d;
    bus.sample_tvalid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      if (bus.sample_tready === 1'b1) acc = 1'b1;
      @(negedge sys_clk);
    end
    bus.sample_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sys_clk);
    checks += 5;
    if (bus.miso !== 1'b0) begin failures++; $display("FAIL rst_miso: got %b expected 0", bus.miso); end
    if (bus.miso_oe !== 1'b0) begin failures++; $display("FAIL rst_oe: got %b expected 0", bus.miso_oe); end
    if (bus.sample_tready !== 1'b0) begin failures++; $display("FAIL rst_tready: got %b expected 0", bus.sample_tready); end
    if (bus.reg_wr_valid !== 1'b0) begin failures++; $display("FAIL rst_wr_valid: got %b expected 0", bus.reg_wr_valid); end
    if (measure_mode !== 1'b0) begin failures++; $display("FAIL rst_measure: got %b expected 0", measure_mode); end
    reset = 1'b0;
    m_reset();
    repeat (3) @(negedge sys_clk);
    checks++;
    if (bus.sample_tready !== 1'b1) begin failures++; $display("FAIL idle_tready: got %b expected 1", bus.sample_tready); end
  endtask

  task automatic test_abort_write();
    mtx[0] = 8'h2D;
    mtx[1] = 8'hFF;
    spi_open(13);
    bus.cs_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (bus.sample_tready !== 1'b1) begin failures++; $display("FAIL abort_idle: tready got %b expected 1", bus.sample_tready); end
    repeat (8) @(negedge sys_clk);
    checks++;
    if (wr_log.size() != 0) begin failures++; $display("FAIL abort_nowrite: got %0d writes expected 0", wr_log.size()); end
    wr_log.delete();
    spi_read(6'h2D, 1'b0, 1);
    checks++;
    if (mrx[1] !== 8'h00) begin failures++; $display("FAIL abort_pctl: got %h expected 00", mrx[1]); end
  endtask

  task automatic test_devid();
    spi_read(6'h00, 1'b0, 2);
    checks += 5;
    if (mrx[0] !== 8'h00) begin failures++; $display("FAIL devid_cmd_miso: got %h expected 00", mrx[0]); end
    if (mrx[1] !== 8'hE5) begin failures++; $display("FAIL devid: got %h expected e5", mrx[1]); end
    if (mrx[2] !== 8'h00) begin failures++; $display("FAIL devid_sb_extra: got %h expected 00", mrx[2]); end
    if (oe_ok !== 1'b1) begin failures++; $display("FAIL devid_oe: got %b expected 1", oe_ok); end
    if (bus.miso_oe !== 1'b0) begin failures++; $display("FAIL devid_oe_off: got %b expected 0", bus.miso_oe); end
  endtask

  task automatic test_write_power();
    spi_write(6'h2D, 8'h08);
    m_regs[45] = 8'h08;
    checks += 3;
    if (wr_log.size() != 1) begin
      failures++; $display("FAIL pwr_wr_count: got %0d expected 1", wr_log.size());
    end else if (wr_log[0] !== {6'h2D, 8'h08}) begin
      failures++; $display("FAIL pwr_wr_entry: got %h expected %h", wr_log[0], {6'h2D, 8'h08});
    end
    if (measure_mode !== 1'b1) begin failures++; $display("FAIL pwr_measure: got %b expected 1", measure_mode); end
    wr_log.delete();
    spi_read(6'h2D, 1'b0, 1);
    if (mrx[1] !== m_read(45)) begin failures++; $display("FAIL pwr_readback: got %h expected %h", mrx[1], m_read(45)); end
  endtask

  task automatic test_sample_read();
    logic acc;
    push_sample(48'h0123_4567_89AB, acc);
    checks++;
    if (acc !== 1'b1) begin failures++; $display("FAIL sample_accept: got %b expected 1", acc); end
    m_sample = 48'h0123_4567_89AB;
    spi_read(6'h32, 1'b1, 6);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (mrx[i+1] !== m_read(50 + i))
        begin failures++; $display("FAIL sample_byte%0d: got %h expected %h", i, mrx[i+1], m_read(50 + i)); end
    end
  endtask

  task automatic test_sample_hold();
    logic [47:0] nxt;
    logic        ready_bad, acc;
    nxt = {16'($urandom), 32'($urandom)};
    ready_bad = 1'b0;
    acc = 1'b0;
    mtx[0] = 8'hF2;
    fork
      begin
        spi_open(56);
        spi_close();
      end
      begin
        repeat (20) @(negedge sys_clk);
        bus.sample_tdata  = nxt;
        bus.sample_tvalid = 1'b1;
        while (bus.cs_n === 1'b0) begin
          if (bus.sample_tready !== 1'b0) ready_bad = 1'b1;
          @(negedge sys_clk);
        end
        for (int k = 0; k < 20 && !acc; k++) begin
          if (bus.sample_tready === 1'b1) acc = 1'b1;
          @(negedge sys_clk);
        end
        bus.sample_tvalid = 1'b0;
      end
    join
    checks += 2;
    if (ready_bad !== 1'b0) begin failures++; $display("FAIL hold_tready_low: got %b expected 0", ready_bad); end
    if (acc !== 1'b1) begin failures++; $display("FAIL hold_accept_after: got %b expected 1", acc); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (mrx[i+1] !== m_read(50 + i))
        begin failures++; $display("FAIL hold_old_byte%0d: got %h expected %h", i, mrx[i+1], m_read(50 + i)); end
    end
    m_sample = nxt;
    spi_read(6'h32, 1'b1, 6);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (mrx[i+1] !== m_read(50 + i))
        begin failures++; $display("FAIL hold_new_byte%0d: got %h expected %h", i, mrx[i+1], m_read(50 + i)); end
    end
  endtask

  // Sample offered in the very cycle the synchronized cs_n fall is seen.
  task automatic test_back_to_back();
    logic [47:0] nxt;
    logic        rdy_at_fall, acc;
    nxt = {16'($urandom), 32'($urandom)};
    rdy_at_fall = 1'b0;
    acc = 1'b0;
    mtx[0] = 8'hF2;
    fork
      begin
        spi_open(56);
        spi_close();
      end
      begin
        repeat (2) @(negedge sys_clk);
        bus.sample_tdata  = nxt;
        bus.sample_tvalid = 1'b1;
        rdy_at_fall = bus.sample_tready;
        if (rdy_at_fall === 1'b1) acc = 1'b1;
        @(negedge sys_clk);
        bus.sample_tvalid = 1'b0;
      end
    join
    checks++;
    if (rdy_at_fall !== 1'b1) begin failures++; $display("FAIL b2b_ready: got %b expected 1", rdy_at_fall); end
    if (acc === 1'b1) m_sample = nxt;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (mrx[i+1] !== m_read(50 + i))
        begin failures++; $display("FAIL b2b_byte%0d: got %h expected %h", i, mrx[i+1], m_read(50 + i)); end
    end
  endtask

  task automatic test_wrap();
    spi_read(6'h3F, 1'b1, 2);
    checks += 2;
    if (mrx[1] !== 8'h00) begin failures++; $display("FAIL wrap_3f: got %h expected 00", mrx[1]); end
    if (mrx[2] !== 8'hE5) begin failures++; $display("FAIL wrap_00: got %h expected e5", mrx[2]); end
    spi_write(6'h00, 8'h12);
    checks += 2;
    if (wr_log.size() != 0) begin failures++; $display("FAIL ro_nowrite: got %0d writes expected 0", wr_log.size()); end
    wr_log.delete();
    spi_read(6'h00, 1'b0, 1);
    if (mrx[1] !== 8'hE5) begin failures++; $display("FAIL ro_devid: got %h expected e5", mrx[1]); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int          a, start, n;
      logic [7:0]  d, exp;
      logic        mb;
      a = $urandom_range(0, 63);
      d = 8'($urandom);
      spi_write(6'(a), d);
      checks++;
      if (m_writable(a)) begin
        m_regs[a] = d;
        if (wr_log.size() != 1 || wr_log[0] !== {6'(a), d})
          begin failures++; $display("FAIL rnd_wr_log[%0d]: got %0d entries expected 1 of %h", it, wr_log.size(), {6'(a), d}); end
      end else if (wr_log.size() != 0) begin
        failures++; $display("FAIL rnd_wr_ignored[%0d]: got %0d entries expected 0 (addr %h)", it, wr_log.size(), a);
      end
      wr_log.delete();
      checks++;
      if (measure_mode !== m_regs[45][3])
        begin failures++; $display("FAIL rnd_measure[%0d]: got %b expected %b", it, measure_mode, m_regs[45][3]); end
      start = $urandom_range(0, 63);
      n     = $urandom_range(1, 4);
      mb    = 1'($urandom);
      spi_read(6'(start), mb, n);
      for (int i = 1; i <= n; i++) begin
        exp = (mb || i == 1) ? m_read(start + i - 1) : 8'h00;
        checks++;
        if (mrx[i] !== exp)
          begin failures++; $display("FAIL rnd_read[%0d] addr %h mb %b byte %0d: got %h expected %h", it, start, mb, i, mrx[i], exp); end
      end
    end
  endtask

  task automatic test_reset_mid();
    mtx[0] = 8'h2D;
    mtx[1] = 8'hA5;
    spi_open(12);
    reset = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks += 2;
    if (bus.miso_oe !== 1'b0) begin failures++; $display("FAIL midrst_oe: got %b expected 0", bus.miso_oe); end
    if (bus.sample_tready !== 1'b0) begin failures++; $display("FAIL midrst_tready: got %b expected 0", bus.sample_tready); end
    reset = 1'b0;
    m_reset();
    spi_close();
    checks += 4;
    if (wr_log.size() != 0) begin failures++; $display("FAIL midrst_nowrite: got %0d expected 0", wr_log.size()); end
    wr_log.delete();
    if (measure_mode !== 1'b0) begin failures++; $display("FAIL midrst_measure: got %b expected 0", measure_mode); end
    spi_read(6'h2C, 1'b1, 2);
    if (mrx[1] !== m_read(44)) begin failures++; $display("FAIL midrst_bwrate: got %h expected %h", mrx[1], m_read(44)); end
    if (mrx[2] !== m_read(45)) begin failures++; $display("FAIL midrst_pctl: got %h expected %h", mrx[2], m_read(45)); end
  endtask

  initial begin
    bus.sclk          = 1'b1;
    bus.cs_n          = 1'b1;
    bus.mosi          = 1'b0;
    bus.sample_tdata  = 48'h0;
    bus.sample_tvalid = 1'b0;
    test_reset();
    test_abort_write();
    test_devid();
    test_write_power();
    test_sample_read();
    test_sample_hold();
    test_back_to_back();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adxl345_responder.md
ADXL345_RESPONDER -- requirements
Module: adxl345_responder

Interface
REQ-001 Parameter SCLK_OVERSAMPLE, default 8, minimum sys_clk cycles per sclk period the block is guaranteed to work at.
REQ-002 sys_clk  input  1  single clock for all logic.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 sclk  input  1  SPI clock, mode 3 (CPOL=1, CPHA=1), asynchronous to sys_clk.
REQ-005 cs_n  input  1  active-low chip select, asynchronous.
REQ-006 mosi  input  1  serial data in, MSB first.
REQ-007 miso  output  1  serial data out, MSB first.
REQ-008 miso_oe  output  1  pad output enable for miso; high only while synchronized cs_n is low.
REQ-009 sample_tdata  input  48  {Z1,Z0,Y1,Y0,X1,X0}, X0 in bits 7:0.
REQ-010 sample_tvalid / sample_tready  input / output  1 each  AXI-stream handshake for new samples.
REQ-011 reg_wr_valid  output  1  one-cycle pulse per accepted register write.
REQ-012 reg_wr_addr / reg_wr_data  output  6 / 8  address and data of that write, valid with reg_wr_valid.
REQ-013 measure_mode  output  1  POWER_CTL bit 3.

Function
REQ-014 sclk, cs_n, mosi SHALL each pass through a 2-flop synchronizer; sclk edges detected from the synchronized value.
REQ-015 FSM states: IDLE, COMMAND, DATA; cs_n synchronized falling edge moves IDLE->COMMAND with bit count 0.
REQ-016 mosi SHALL be sampled on synchronized sclk rising edges; miso SHALL change on synchronized sclk falling edges only.
REQ-017 COMMAND: 8 bits captured as {RW, MB, ADDR[5:0]}; miso driven 0; after 8th rising edge -> DATA.
REQ-018 Read (RW=1): register ADDR latched into the shift register before the next falling edge; bits 7..0 output on the following 8 falling edges.
REQ-019 Write (RW=0): 8 data bits captured; on 8th rising edge, if ADDR writable, register updated and reg_wr_valid pulsed the next cycle; non-writable addresses ignored, no pulse; miso driven 0.
REQ-020 MB=1: after each complete data byte ADDR increments (0x3F wraps to 0x00) and DATA repeats while cs_n low; MB=0: further bits until cs_n rise are ignored, miso 0.
REQ-021 Register map: 0x00 DEVID=0xE5 RO; 0x2C BW_RATE reset 0x0A RW; 0x2D POWER_CTL, 0x2E INT_ENABLE, 0x31 DATA_FORMAT, 0x38 FIFO_CTL reset 0x00 RW; 0x32-0x37 data RO; all others read 0x00, writes ignored.
REQ-022 sample_tready SHALL be high only in IDLE with synchronized cs_n high; on handshake all six data registers update in the same cycle (coherent multi-byte reads).
REQ-023 cs_n rise in any state SHALL return to IDLE within 3 sys_clk cycles; partial byte discarded, no write, miso_oe low.
REQ-024 sample handshake and cs_n fall in the same cycle: sample accepted, transfer starts next cycle.

Reset
REQ-025 reset SHALL force IDLE, bit count 0, miso=0, miso_oe=0, sample_tready=0, reg_wr_valid=0, synchronizers to idle (sclk=1, cs_n=1), registers to REQ-021 reset values, data registers 0x00.
REQ-026 Reset asserted mid-transfer SHALL abort it; after release the block waits for a fresh cs_n falling edge before decoding.

Structure
REQ-027 Register addresses, reset values, DEVID constant and the state enum SHALL live in a shared package adxl345_pkg, also used by the adxl345 driver.
REQ-028 One sub-module spi_slave_sync (3-bit synchronizer plus sclk edge detector) is natural; everything else in this module.

Verification
REQ-029 Read 0x00 (command 0x80, MB=0) -> miso returns 0xE5 in bits 8..15.
REQ-030 Write 0x2D data 0x08 -> reg_wr_valid once with addr 0x2D data 0x08, measure_mode=1; subsequent read 0xAD returns 0x08.
REQ-031 Sample 0x0123_4567_89AB accepted, then MB read from 0x32 (command 0xF2), 6 bytes -> 0xAB,0x89,0x67,0x45,0x23,0x01.
REQ-032 sample_tvalid held during a transfer -> sample_tready low until cs_n high; data registers unchanged mid-read.
REQ-033 Write 0x2D, cs_n raised after 5 data bits -> no reg_wr_valid, POWER_CTL stays 0x00, FSM IDLE.
REQ-034 MB read from 0x3F for 2 bytes -> 0x00 then 0xE5 (wrap); write to 0x00 with 0x12 -> ignored, DEVID still 0xE5.
